quarter_wave_nco: RTL and testbench
===================================

Name: quarter_wave_nco

Overview:
- Phase-accumulator address generator that sits directly upstream of the quarter-wave sine LUT (memory, 1-cycle registered read) and its DAC output stage.
- Each sample tick it advances the phase by a programmable tuning word. It emits the 7-bit LUT read address, already mirrored for descending quadrants.
- It also emits the quadrant flags, delayed by one cycle so they line up with the LUT data, for inversion and MSB selection downstream.
- Frequency changes take effect only at a full-period wrap, so the output waveform never glitches.

Parameters:
- PHASE_W, 16, phase accumulator width; bits [PHASE_W-1:PHASE_W-2] are the quadrant.
- ADDR_W, 7, LUT address width; taken from phase bits [PHASE_W-3:PHASE_W-2-ADDR_W].
- PRESCALE, 1, clk cycles per sample tick (>=1; 1 = tick every enabled cycle).
- TW_RESET, 128, tuning word after reset (one LUT step per tick, 512-tick period).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run; when low, prescaler and phase hold.
- phase_clear  in  1  synchronous: phase := 0, prescaler := 0.
- tw_in  in  PHASE_W  new tuning word.
- tw_load  in  1  1-cycle strobe; captures tw_in into the pending register.
- lut_address  out  ADDR_W  LUT read address (registered).
- quadrant  out  2  quadrant of the current lut_address (registered, same cycle as lut_address).
- addr_valid  out  1  1-cycle pulse when a new lut_address is presented.
- data_invert  out  1  quadrant[1] delayed 1 cycle; aligned with LUT data.
- data_valid  out  1  addr_valid delayed 1 cycle; aligned with LUT data.
- wrap  out  1  1-cycle pulse, coincident with addr_valid, when the phase overflows past 2^PHASE_W.
- active_tw  out  PHASE_W  tuning word currently in use.

Behaviour:
- Reset (async, rst_n=0):
  - phase=0, prescaler=0, lut_address=0, quadrant=0.
  - addr_valid=0, data_valid=0, data_invert=0, wrap=0.
  - active_tw=TW_RESET, pending=TW_RESET, pending_flag=0.
- Reset release:
  - First tick occurs PRESCALE enabled cycles after deassertion.
  - Reset asserted mid-operation overrides everything immediately; it is not deferred to a wrap.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1.
  - tick is asserted when the count equals PRESCALE-1; the count then returns to 0.
  - When enable=0, the count holds and no tick occurs.
- On tick:
  - phase_next = phase + active_tw, computed modulo 2^PHASE_W.
  - The carry out of that addition is the wrap event.
  - The registered outputs are updated from phase_next:
    - q = phase_next[PHASE_W-1:PHASE_W-2]; idx = phase_next[PHASE_W-3 -: ADDR_W].
    - lut_address = idx when q is 0 or 2; lut_address = ~idx (that is, 127 - idx) when q is 1 or 3.
    - quadrant = q; addr_valid = 1; wrap = carry.
- Quadrant meaning: q0 ascending/positive, q1 descending/positive, q2 ascending/negative, q3 descending/negative.
- Alignment pipeline: data_invert and data_valid are quadrant[1] and addr_valid registered once more. They match the LUT's 1-cycle read latency.
- Tuning word:
  - tw_load sets pending = tw_in and pending_flag = 1. A later tw_load before the wrap overwrites pending (last write wins).
  - On a tick with carry=1 and pending_flag=1: active_tw = pending, pending_flag = 0. The new word is used from the next tick.
  - If tw_load and the wrap tick fall in the same cycle, tw_in is applied directly, bypassing pending.
  - If enable=0, a tw_load is applied to active_tw immediately.
  - active_tw = 0 is legal: the phase freezes while ticks and addr_valid continue.
- phase_clear:
  - Highest priority, ahead of tick and tw apply.
  - Effects: phase=0, prescaler=0, lut_address=0, quadrant=0, addr_valid=0, wrap=0.
  - pending and pending_flag are untouched.
- Widths:
  - The accumulator is unsigned and wraps naturally.
  - Fraction bits (the low PHASE_W-2-ADDR_W bits) are never output; no rounding is applied.

Decomposition:
- Shared package nco_pkg holds:
  - quadrant enum Q1=2'b00, Q2=2'b01, Q3=2'b10, Q4=2'b11, with helpers is_reverse(q)=q[0] and is_negative(q)=q[1];
  - default widths PHASE_W and ADDR_W;
  - the TW_RESET constant.
- One natural sub-module, tick_prescaler (parameter PRESCALE; ports clk, rst_n, enable, clear, tick).
- Everything else lives in quarter_wave_nco.

Test Plan:
- Reset and default rate: PRESCALE=1, TW_RESET=128, enable=1.
  - lut_address runs 1..127; at the 128th tick quadrant becomes 1 with address 127, then 126..0.
  - quadrant 2 ascends, quadrant 3 descends.
  - wrap pulses on the 512th tick; data_invert is high exactly during ticks 257..512, each one cycle later than addr_valid.
- Prescale: PRESCALE=4, tw=128.
  - addr_valid pulses every 4th cycle; with enable dropped for 3 cycles, the next pulse arrives 3 cycles late and the address sequence is unbroken.
- Glitch-free retune: at phase 0x2000, tw_in=256 with tw_load.
  - active_tw stays 128 until the wrap tick, then becomes 256; the next period lasts 256 ticks and the addresses step by 2.
- Same-cycle load and wrap: tw_load(512) on the wrap tick.
  - active_tw=512 on the following cycle; pending_flag=0.
- phase_clear plus tick in the same cycle, with phase at 0x9000:
  - lut_address=0, quadrant=0, addr_valid=0; the next tick yields address 1 (tw=128).
- Async reset mid-period at quadrant 3, address 40, with a load pending:
  - all outputs return to their reset values without waiting for a clk edge; active_tw=128, and the pending word is discarded.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared types and defaults for the quarter-wave NCO address generator.
// Quadrant encoding plus helpers for address mirroring and output inversion.
package nco_pkg;

    typedef enum logic [1:0] {
        Q1 = 2'b00,
        Q2 = 2'b01,
        Q3 = 2'b10,
        Q4 = 2'b11
    } quadrant_e;

    localparam int NCO_PHASE_W  = 16;
    localparam int NCO_ADDR_W   = 7;
    localparam int NCO_TW_RESET = 128;

    // Descending quadrants read the LUT backwards.
    function automatic logic is_reverse(input logic [1:0] q);
        return q[0];
    endfunction

    function automatic logic is_negative(input logic [1:0] q);
        return q[1];
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Sample-tick generator: one tick every PRESCALE enabled clk cycles.
// The count freezes while enable is low; clear restarts the count.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/quarter_wave_nco.sv
// Phase accumulator feeding a quarter-wave sine LUT: mirrored read address,
// quadrant flags aligned to the LUT's registered read, wrap-synchronous retune.
module quarter_wave_nco
    import nco_pkg::*;
#(
    parameter int                 PHASE_W  = NCO_PHASE_W,
    parameter int                 ADDR_W   = NCO_ADDR_W,
    parameter int                 PRESCALE = 1,
    parameter logic [PHASE_W-1:0] TW_RESET = PHASE_W'(NCO_TW_RESET)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               phase_clear,
    input  logic [PHASE_W-1:0] tw_in,
    input  logic               tw_load,
    output logic [ADDR_W-1:0]  lut_address,
    output logic [1:0]         quadrant,
    output logic               addr_valid,
    output logic               data_invert,
    output logic               data_valid,
    output logic               wrap,
    output logic [PHASE_W-1:0] active_tw
);

    logic [PHASE_W-1:0] phase, phase_next, pending;
    logic               pending_flag, carry, tick, wrap_tick;
    logic [1:0]         q_next;
    logic [ADDR_W-1:0]  idx_next, addr_next;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .clear  (phase_clear),
        .tick   (tick)
    );

    assign {carry, phase_next} = {1'b0, phase} + {1'b0, active_tw};
    assign q_next    = phase_next[PHASE_W-1 -: 2];
    assign idx_next  = phase_next[PHASE_W-3 -: ADDR_W];
    assign addr_next = is_reverse(q_next) ? ~idx_next : idx_next;
    assign wrap_tick = tick && carry && !phase_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= '0;
            lut_address <= '0;
            quadrant    <= 2'b00;
            addr_valid  <= 1'b0;
            wrap        <= 1'b0;
            data_invert <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            if (phase_clear) begin
                phase       <= '0;
                lut_address <= '0;
                quadrant    <= 2'b00;
                addr_valid  <= 1'b0;
                wrap        <= 1'b0;
            end else if (tick) begin
                phase       <= phase_next;
                lut_address <= addr_next;
                quadrant    <= q_next;
                addr_valid  <= 1'b1;
                wrap        <= carry;
            end else begin
                addr_valid  <= 1'b0;
                wrap        <= 1'b0;
            end
            // One extra stage to match the LUT's registered read.
            data_invert <= is_negative(quadrant);
            data_valid  <= addr_valid;
        end
    end

    // Retune only at a full-period wrap; when idle there is no waveform to glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_tw    <= TW_RESET;
            pending      <= TW_RESET;
            pending_flag <= 1'b0;
        end else if (tw_load && (!enable || wrap_tick)) begin
            active_tw    <= tw_in;
            pending      <= tw_in;
            pending_flag <= 1'b0;
        end else if (wrap_tick && pending_flag) begin
            active_tw    <= pending;
            pending_flag <= 1'b0;
        end else if (tw_load) begin
            pending      <= tw_in;
            pending_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quarter_wave_nco.sv
// Directed bench: default-rate sweep, prescaled ticking with enable gaps,
// wrap-synchronous retune, same-cycle load on wrap, phase_clear and async reset.
module tb_quarter_wave_nco;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, clr_a, ld_a, en_b, clr_b, ld_b;
    logic [15:0] tw_a, tw_b;
    logic [6:0]  addr_a, addr_b;
    logic [1:0]  quad_a, quad_b;
    logic        av_a, di_a, dv_a, wr_a, av_b, di_b, dv_b, wr_b;
    logic [15:0] atw_a, atw_b;

    int checks = 0;
    int failures = 0;
    int q, r, np;
    int pulses_b[5] = '{4, 8, 12, 19, 23};
    logic exp_av, prev_av;

    always #5 clk = ~clk;

    quarter_wave_nco dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .phase_clear(clr_a),
        .tw_in(tw_a), .tw_load(ld_a), .lut_address(addr_a), .quadrant(quad_a),
        .addr_valid(av_a), .data_invert(di_a), .data_valid(dv_a), .wrap(wr_a),
        .active_tw(atw_a)
    );

    quarter_wave_nco #(.PRESCALE(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .phase_clear(clr_b),
        .tw_in(tw_b), .tw_load(ld_b), .lut_address(addr_b), .quadrant(quad_b),
        .addr_valid(av_b), .data_invert(di_b), .data_valid(dv_b), .wrap(wr_b),
        .active_tw(atw_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 0; clr_a = 0; ld_a = 0; tw_a = '0;
        en_b = 0; clr_b = 0; ld_b = 0; tw_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(addr_a), 0);
        chk("rst_quad", 32'(quad_a), 0);
        chk("rst_av", 32'(av_a), 0);
        chk("rst_dv", 32'(dv_a), 0);
        chk("rst_inv", 32'(di_a), 0);
        chk("rst_wrap", 32'(wr_a), 0);
        chk("rst_tw", 32'(atw_a), 128);
        chk("rst_b", 32'({addr_b, quad_b, wr_b, di_b}), 0);
        chk("rst_b_tw", 32'(atw_b), 128);

        // Prescale 4: pulses every 4th cycle, enable gap of 3 cycles delays one by 3.
        rst_n = 1'b1;
        np = 0;
        prev_av = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            en_b = !(c >= 13 && c <= 15);
            @(negedge clk);
            exp_av = (np < 5) && (c == pulses_b[np]);
            chk("b_av", 32'(av_b), 32'(exp_av));
            chk("b_dv", 32'(dv_b), 32'(prev_av));
            if (exp_av) begin
                np++;
                chk("b_addr", 32'(addr_b), 32'(np));
            end
            prev_av = exp_av;
        end
        en_b = 1'b0;

        // Default rate, one full 512-tick period.
        en_a = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            @(negedge clk);
            q = (k / 128) % 4;
            r = k % 128;
            chk("a_addr", 32'(addr_a), 32'((q % 2 != 0) ? 127 - r : r));
            chk("a_quad", 32'(quad_a), 32'(q));
            chk("a_av", 32'(av_a), 1);
            chk("a_wrap", 32'(wr_a), 32'(k == 512));
            chk("a_dv", 32'(dv_a), 32'(k > 1));
            chk("a_inv", 32'(di_a), 32'(k >= 257));
        end

        // Retune mid-period (phase 0x2000): deferred to wrap; last load wins.
        for (int j = 1; j <= 512; j++) begin
            ld_a = (j == 65) || (j == 70);
            tw_a = (j == 65) ? 16'd300 : 16'd256;
            @(negedge clk);
            q = (j / 128) % 4;
            r = j % 128;
            chk("rt_addr", 32'(addr_a), 32'((q % 2 != 0) ? 127 - r : r));
            chk("rt_wrap", 32'(wr_a), 32'(j == 512));
            chk("rt_tw", 32'(atw_a), (j == 512) ? 256 : 128);
        end

        // 256-tick period at step 2; stale pending 768, then load 512 on the wrap tick.
        for (int j = 1; j <= 256; j++) begin
            ld_a = (j == 10) || (j == 256);
            tw_a = (j == 10) ? 16'd768 : 16'd512;
            @(negedge clk);
            q = (2 * j / 128) % 4;
            r = (2 * j) % 128;
            chk("x2_addr", 32'(addr_a), 32'((q % 2 != 0) ? 127 - r : r));
            chk("x2_wrap", 32'(wr_a), 32'(j == 256));
            chk("x2_tw", 32'(atw_a), (j == 256) ? 512 : 256);
        end
        ld_a = 1'b0;

        // The same-cycle load must have dropped the pending word.
        for (int m = 1; m <= 128; m++) begin
            @(negedge clk);
            q = (4 * m / 128) % 4;
            r = (4 * m) % 128;
            chk("x4_addr", 32'(addr_a), 32'((q % 2 != 0) ? 127 - r : r));
            chk("x4_wrap", 32'(wr_a), 32'(m == 128));
            chk("x4_tw", 32'(atw_a), 512);
        end

        // Load while disabled applies at once.
        en_a = 1'b0; tw_a = 16'd128; ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0;
        chk("idle_tw", 32'(atw_a), 128);
        chk("idle_av", 32'(av_a), 0);

        // Run to phase 0x9000, then clear coincident with a tick.
        en_a = 1'b1;
        repeat (288) @(negedge clk);
        chk("p9_addr", 32'(addr_a), 32);
        chk("p9_quad", 32'(quad_a), 2);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("clr_addr", 32'(addr_a), 0);
        chk("clr_quad", 32'(quad_a), 0);
        chk("clr_av", 32'(av_a), 0);
        chk("clr_wrap", 32'(wr_a), 0);
        @(negedge clk);
        chk("clr_next_addr", 32'(addr_a), 1);
        chk("clr_next_av", 32'(av_a), 1);

        // Advance to quadrant 3 address 40 with a pending load of 1000.
        for (int i = 1; i <= 470; i++) begin
            ld_a = (i == 1);
            tw_a = 16'd1000;
            @(negedge clk);
        end
        ld_a = 1'b0;
        chk("q3_addr", 32'(addr_a), 40);
        chk("q3_quad", 32'(quad_a), 3);
        chk("q3_tw", 32'(atw_a), 128);

        // Async reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", 32'(addr_a), 0);
        chk("ar_quad", 32'(quad_a), 0);
        chk("ar_av", 32'(av_a), 0);
        chk("ar_dv", 32'(dv_a), 0);
        chk("ar_inv", 32'(di_a), 0);
        chk("ar_wrap", 32'(wr_a), 0);
        chk("ar_tw", 32'(atw_a), 128);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            @(negedge clk);
            if (k == 1) chk("ar_first_addr", 32'(addr_a), 1);
            chk("ar_run_tw", 32'(atw_a), 128);
            chk("ar_run_wrap", 32'(wr_a), 32'(k == 512));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
